// File: rtl/c2_loader_initiator.sv
// c2_loader_initiator: host-side C2 loader initiator, image memory -> UART.
// Optional checksum byte before the final ACK: define LOADER_INIT_CHECKSUM_EN.
module c2_loader_initiator #(
    parameter logic [7:0]  CMD_LOAD_IMEM = 8'h1C,
    parameter logic [7:0]  CMD_LOAD_DMEM = 8'h1D,
    parameter logic [7:0]  ACK_BYTE      = 8'hAC,
    parameter int unsigned ACK_TIMEOUT   = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        target_i,
    input  logic [15:0] word_count_i,
    output logic [15:0] img_addr_o,
    input  logic [31:0] img_data_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  err_code_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

`ifdef LOADER_INIT_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ACK1, S_LEN, S_FETCH, S_WORD,
        S_CSUM, S_ACK2, S_DONE, S_ERROR
    } state_e;
    localparam state_e S_TAIL = S_CSUM;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ACK1, S_LEN, S_FETCH, S_WORD,
        S_ACK2, S_DONE, S_ERROR
    } state_e;
    localparam state_e S_TAIL = S_ACK2;
`endif

    state_e        state_q, state_d;
    logic          target_q, target_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   addr_q, addr_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    code_q, code_d;
`ifdef LOADER_INIT_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic       snd;
    logic [7:0] cur;
    logic       sent;

    // A byte is complete only when the UART reports done for our own request.
    assign sent = pend_q & tx_done_i;

    // Next-state, byte selection and transmit handshake.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        count_d    = count_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tmo_d      = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        code_d     = code_q;
`ifdef LOADER_INIT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        snd        = 1'b0;
        cur        = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    target_d = target_i;
                    count_d  = word_count_i;
                    error_d  = 1'b0;
                    code_d   = 2'd0;
                    busy_d   = 1'b1;
                    idx_d    = 2'd0;
                    addr_d   = 16'd0;
`ifdef LOADER_INIT_CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                snd = 1'b1;
                cur = target_q ? CMD_LOAD_DMEM : CMD_LOAD_IMEM;
                if (sent) state_d = S_ACK1;
            end
            S_ACK1, S_ACK2: begin
                if (rx_ready_i) begin
                    if (rx_data_i == ACK_BYTE) begin
                        if (state_q == S_ACK1) begin
                            idx_d   = 2'd0;
                            state_d = S_LEN;
                        end else begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_DONE;
                        end
                    end else begin
                        error_d = 1'b1;
                        code_d  = 2'd2;
                        busy_d  = 1'b0;
                        state_d = S_ERROR;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    code_d  = 2'd1;
                    busy_d  = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_LEN: begin
                snd = 1'b1;
                cur = idx_q[0] ? count_q[15:8] : count_q[7:0];
                if (sent) begin
                    if (idx_q[0]) begin
                        idx_d = 2'd0;
                        if (count_q == 16'd0) begin
                            state_d = S_TAIL;
                        end else begin
                            addr_d  = 16'd0;
                            state_d = S_FETCH;
                        end
                    end else begin
                        idx_d = 2'd1;
                    end
                end
            end
            S_FETCH: begin
                // First cycle presents the address, second captures the word.
                if (idx_q[0]) begin
                    shift_d = img_data_i;
                    idx_d   = 2'd0;
                    state_d = S_WORD;
                end else begin
                    idx_d = 2'd1;
                end
            end
            S_WORD: begin
                snd = 1'b1;
                cur = shift_q[7:0];
                if (sent) begin
                    shift_d = {8'h00, shift_q[31:8]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (addr_q == count_q - 16'd1) begin
                            state_d = S_TAIL;
                        end else begin
                            addr_d  = addr_q + 16'd1;
                            state_d = S_FETCH;
                        end
                    end
                end
            end
`ifdef LOADER_INIT_CHECKSUM_EN
            S_CSUM: begin
                snd = 1'b1;
                cur = csum_q;
                if (sent) state_d = S_ACK2;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (snd && !pend_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = cur;
            pend_d     = 1'b1;
`ifdef LOADER_INIT_CHECKSUM_EN
            if (state_q == S_LEN || state_q == S_WORD)
                csum_d = csum_q ^ cur;
`endif
        end
        if (sent) pend_d = 1'b0;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            count_q    <= 16'd0;
            addr_q     <= 16'd0;
            shift_q    <= 32'd0;
            idx_q      <= 2'd0;
            pend_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= 2'd0;
`ifdef LOADER_INIT_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            code_q     <= code_d;
`ifdef LOADER_INIT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign img_addr_o = addr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = code_q;

endmodule
